// File: rtl/time_of_day_core.sv
// Time-of-day engine: one prescaler drives binary sec/min/hour counters, with
// debounced keys steering a three-field set mode and a blink divider for feedback.
module time_of_day_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2,
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic        inputClock,
    input  logic        nReset,
    input  logic        pause,
    input  logic        mode12,
    input  logic        nSelect,
    input  logic        nAdvance,
    input  logic        nClear,
    output logic [23:0] time_bcd,
    output logic [5:0]  blank_mask,
    output logic        pm,
    output logic        sec_pulse,
    output logic        setting,
    output logic [1:0]  state_dbg
);

    localparam int PS_W       = $clog2(CLK_HZ);
    localparam int DB_W       = $clog2(DEBOUNCE + 1);
    localparam int BLINK_HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int BL_W       = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_SET_SEC  = 2'd1,
        S_SET_MIN  = 2'd2,
        S_SET_HOUR = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PS_W-1:0]   presc;
    logic [5:0]        sec, min;
    logic [4:0]        hour;
    logic [4:0]        hour_disp;
    logic [BL_W-1:0]   blink_cnt;
    logic              blink_phase;
    logic              tick;
    logic [2:0]        key_raw;
    logic [2:0]        key_press;
    logic              sel_ev, adv_ev, clr_ev;

    // Key order: 0 = select, 1 = advance, 2 = clear. All keys idle high.
    assign key_raw = {nClear, nAdvance, nSelect};

    for (genvar k = 0; k < 3; k++) begin : g_key
        logic            s1, s2, level, press_q;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge inputClock or negedge nReset) begin
            if (!nReset) begin
                s1      <= 1'b1;
                s2      <= 1'b1;
                level   <= 1'b1;
                db_cnt  <= '0;
                press_q <= 1'b0;
            end else begin
                s1      <= key_raw[k];
                s2      <= s1;
                press_q <= 1'b0;
                if (s2 == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                    // New level held long enough; only the falling edge is an event.
                    db_cnt  <= '0;
                    level   <= s2;
                    press_q <= ~s2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign key_press[k] = press_q;
    end

    assign sel_ev = key_press[0];
    assign adv_ev = key_press[1];
    assign clr_ev = key_press[2];

    always_ff @(posedge inputClock or negedge nReset) begin
        if (!nReset) state <= S_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        setting    = 1'b0;
        blank_mask = '0;
        case (state)
            S_RUN: begin
                if (sel_ev) state_nxt = S_SET_SEC;
            end
            S_SET_SEC: begin
                setting = 1'b1;
                if (blink_phase) blank_mask = 6'b000011;
                if (sel_ev) state_nxt = S_SET_MIN;
            end
            S_SET_MIN: begin
                setting = 1'b1;
                if (blink_phase) blank_mask = 6'b001100;
                if (sel_ev) state_nxt = S_SET_HOUR;
            end
            S_SET_HOUR: begin
                setting = 1'b1;
                if (blink_phase) blank_mask = 6'b110000;
                if (sel_ev) state_nxt = S_RUN;
            end
        endcase
    end

    assign state_dbg = state;
    assign tick      = (state == S_RUN) && !pause && (presc == PS_W'(CLK_HZ - 1));

    // Prescaler sits at 0 throughout set mode so the first second after exit is full.
    always_ff @(posedge inputClock or negedge nReset) begin
        if (!nReset) begin
            presc     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
            if (state != S_RUN)  presc <= '0;
            else if (tick)       presc <= '0;
            else if (!pause)     presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge inputClock or negedge nReset) begin
        if (!nReset) begin
            sec  <= '0;
            min  <= '0;
            hour <= '0;
        end else if (tick) begin
            if (sec == 6'd59) begin
                sec <= '0;
                if (min == 6'd59) begin
                    min  <= '0;
                    hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    min <= min + 6'd1;
                end
            end else begin
                sec <= sec + 6'd1;
            end
        end else if (state != S_RUN && !sel_ev) begin
            // Set-mode edits touch only the selected field; clear wins over advance.
            if (clr_ev) begin
                case (state)
                    S_SET_SEC:  sec  <= '0;
                    S_SET_MIN:  min  <= '0;
                    S_SET_HOUR: hour <= '0;
                    default: ;
                endcase
            end else if (adv_ev) begin
                case (state)
                    S_SET_SEC:  sec  <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                    S_SET_MIN:  min  <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                    S_SET_HOUR: hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    default: ;
                endcase
            end
        end
    end

    // Blink divider restarts at phase 0 whenever a select event changes the field.
    always_ff @(posedge inputClock or negedge nReset) begin
        if (!nReset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == S_RUN || sel_ev) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if      (v >= 6'd50) tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        units = 4'(v - 6'(tens) * 6'd10);
        return {tens, units};
    endfunction

    always_comb begin
        hour_disp = hour;
        if (mode12) begin
            if (hour == 5'd0)      hour_disp = 5'd12;
            else if (hour > 5'd12) hour_disp = hour - 5'd12;
        end
    end

    assign time_bcd = {to_bcd({1'b0, hour_disp}), to_bcd(min), to_bcd(sec)};
    assign pm       = (hour >= 5'd12);

endmodule

// File: doc/time_of_day_core.md
Name: time_of_day_core

Overview:
Single-clock-domain time-of-day engine that replaces the rippled per-digit counter chain with one synchronous prescaler and field counters. It runs from the board clock and produces packed BCD time (HH:MM:SS). It supports 12/24-hour display, a pause input and a debounced three-field set-mode state machine. Per-digit blanking gives blink feedback. It sits between the board keys/switches and the six HexDisplayTranslator instances.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; prescaler period in cycles (min 4).
BLINK_HZ, 2, blink rate of the selected field in set mode.
DEBOUNCE, 1_000_000, cycles a synchronised key level must be stable before it is accepted (min 1).

Ports:
inputClock  in  1  board clock, all state on rising edge.
nReset  in  1  asynchronous active-low reset.
pause  in  1  high: prescaler holds, time frozen.
mode12  in  1  high: 12-hour display; low: 24-hour.
nSelect  in  1  raw active-low key: cycle set-mode field.
nAdvance  in  1  raw active-low key: increment selected field.
nClear  in  1  raw active-low key: zero selected field.
time_bcd  out  24  {Htens,Hunits,Mtens,Munits,Stens,Sunits}, 4 bits each.
blank_mask  out  6  bit i high: digit i (0 = Sunits) must be blanked.
pm  out  1  high when internal hour >= 12, in either mode.
sec_pulse  out  1  one-cycle pulse per elapsed second.
setting  out  1  high whenever FSM is not RUN.

Behaviour:
- Reset (async, nReset low): time 00:00:00 (internal hour 0), prescaler 0, blink phase 0, FSM RUN, debouncers idle (released). Outputs: time_bcd reflects display mapping (24h: 0x000000; 12h: 0x120000), blank_mask 0, pm 0, sec_pulse 0, setting 0.
- Internal state is binary: sec 0-59, min 0-59, hour 0-23. BCD conversion is combinational from registers.
- Display mapping in 12h mode: hour 0 -> 12; 1-12 -> same; 13-23 -> hour-12. mode12 is purely a display mapping; toggling it never alters stored time.
- Prescaler: counts 0..CLK_HZ-1 in RUN with pause low. On the edge where it equals CLK_HZ-1: it goes to 0, time advances 1 s, and sec_pulse is high for the next cycle.
- Carry chain: sec 59 -> 0 carries to min; min 59 -> 0 carries to hour; hour 23 -> 0. 23:59:59 + 1 s = 00:00:00.
- Pause high: prescaler and time hold; pause low resumes from the held count.
- Keys: each key passes through a 2-FF synchroniser, then a debouncer. The accepted level changes only after DEBOUNCE consecutive cycles at the new level. A press is a falling edge of the accepted level and gives a 1-cycle event. Release generates nothing. The field updates on the edge after the event.
- FSM states: RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN, advancing on each select event.
- In any SET state, prescaler is held at 0 and no ticks occur. On exit SET_HOUR -> RUN, prescaler restarts at 0, so the first second is a full period.
- Advance event: increments the selected field modulo 60/60/24 with no carry into other fields.
- Clear event: sets the selected field to 0.
- Advance and clear in RUN are ignored.
- Simultaneous events in one cycle: select has priority and the others are dropped; clear beats advance.
- Blink: a divider toggles phase every CLK_HZ/(2*BLINK_HZ) cycles. It runs only in SET states and resets to phase 0 on entry to each SET state. When phase is 1, blank_mask is high for the selected field's two digits (SET_SEC bits 1:0, SET_MIN 3:2, SET_HOUR 5:4). In RUN, blank_mask is 0.
- Reset mid-operation: immediate return to reset values, including mid-debounce and mid-set.

Test Plan:
Sim uses CLK_HZ=10, BLINK_HZ=1, DEBOUNCE=2.
1. Release reset, run 600 cycles -> time_bcd 0x000100; exactly 60 sec_pulse; first pulse in the cycle after cycle 9.
2. Force time to 23:59:59 via set mode, run 10 cycles -> 0x000000, pm falls 1 -> 0. With mode12=1 at 13:05:00 -> 0x010500 with pm=1; mode12=0 -> 0x130500.
3. Press select once, advance 3 times at 00:00:58 -> SET_SEC, sec 58 -> 59 -> 0 -> 1, min unchanged. blank_mask toggles 0x00/0x03 every 5 cycles; no sec_pulse.
4. Select to SET_HOUR at hour 23, advance -> hour 0. Clear in SET_MIN -> min 0. Select+advance pressed in the same cycle -> state moves, field unchanged. A glitch low for 1 cycle -> no event.
5. Assert pause for 37 cycles mid-second -> time frozen, then resumes with residual count preserved. Assert nReset low mid-SET_MIN with keys held -> all outputs at reset values asynchronously; setting 0.
